// File: rtl/kernel_mhsa_pkg.sv
// Shared constants and helpers for the MHSA multiplier pipeline.
// Width math, rounding constant, saturation limits and lane slicing.
package kernel_mhsa_pkg;

    localparam int MAX_W = 256;

    function automatic int p_w(input int a_w, input int b_w);
        return a_w + b_w + 1;
    endfunction

    function automatic logic [MAX_W-1:0] round_const(input int shift, input int rnd);
        logic [MAX_W-1:0] r;
        r = '0;
        if (rnd != 0 && shift > 0) begin
            r = MAX_W'(1) << (shift - 1);
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] sat_max(input int out_w);
        return (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
    endfunction

    // Two's complement of -2^(out_w-1), sign-extended to MAX_W.
    function automatic logic [MAX_W-1:0] sat_min(input int out_w);
        return ~sat_max(out_w);
    endfunction

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/kernel_mhsa_mul_lane.sv
// One lane: signed x (un)signed multiply, round, arithmetic shift,
// then saturate or wrap to OUT_W. All stages advance on adv.
module kernel_mhsa_mul_lane
    import kernel_mhsa_pkg::*;
#(
    parameter int A_W       = 32,
    parameter int B_W       = 24,
    parameter int OUT_W     = 32,
    parameter int SHIFT     = 16,
    parameter int ROUND     = 1,
    parameter int SAT       = 1,
    parameter int NUM_STAGE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             b_signed,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic [OUT_W-1:0] data,
    output logic             sat
);

    localparam int PW = p_w(A_W, B_W);
    localparam int RW = PW + 1;
    localparam logic signed [RW-1:0] RC   = RW'(round_const(SHIFT, ROUND));
    localparam logic signed [RW-1:0] MAXV = RW'(sat_max(OUT_W));
    localparam logic signed [RW-1:0] MINV = RW'(sat_min(OUT_W));

    logic signed [B_W:0]    b_ext;
    logic signed [A_W-1:0]  a_s;
    logic signed [B_W:0]    b_s;
    logic signed [PW-1:0]   p_m;
    logic signed [PW-1:0]   p_f;
    logic signed [RW-1:0]   sum;
    logic signed [RW-1:0]   r;
    logic [OUT_W-1:0]       d_n;
    logic                   s_n;

    assign b_ext = b_signed ? {b[B_W-1], b} : {1'b0, b};

    // Operand registers are left unreset so they pack into DSP input regs.
    if (NUM_STAGE == 1) begin : g_comb
        assign a_s = a;
        assign b_s = b_ext;
    end else begin : g_reg
        logic signed [A_W-1:0] a_q;
        logic signed [B_W:0]   b_q;
        always_ff @(posedge clk) begin
            if (adv) begin
                a_q <= a;
                b_q <= b_ext;
            end
        end
        assign a_s = a_q;
        assign b_s = b_q;
    end

    assign p_m = PW'(a_s) * PW'(b_s);

    if (NUM_STAGE <= 2) begin : g_pdir
        assign p_f = p_m;
    end else begin : g_ppipe
        logic signed [PW-1:0] p_q [NUM_STAGE-2];
        always_ff @(posedge clk) begin
            if (adv) begin
                p_q[0] <= p_m;
                for (int k = 1; k < NUM_STAGE - 2; k++) begin
                    p_q[k] <= p_q[k-1];
                end
            end
        end
        assign p_f = p_q[NUM_STAGE-3];
    end

    // One extra bit of headroom so the rounding add cannot overflow.
    assign sum = {p_f[PW-1], p_f} + RC;
    assign r   = sum >>> SHIFT;

    always_comb begin
        d_n = r[OUT_W-1:0];
        s_n = 1'b0;
        if (SAT != 0) begin
            if (r > MAXV) begin
                d_n = MAXV[OUT_W-1:0];
                s_n = 1'b1;
            end else if (r < MINV) begin
                d_n = MINV[OUT_W-1:0];
                s_n = 1'b1;
            end
        end else begin
            s_n = (r[RW-1:OUT_W] != {(RW-OUT_W){r[OUT_W-1]}});
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data <= '0;
            sat  <= 1'b0;
        end else if (adv) begin
            data <= d_n;
            sat  <= s_n;
        end
    end

endmodule

// File: rtl/kernel_mhsa_mul_pipe.sv
// Multi-lane MHSA scale multiplier with valid/ready handshake,
// per-stage valid chain and sticky saturation flags.
module kernel_mhsa_mul_pipe
    import kernel_mhsa_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int A_W       = 32,
    parameter int B_W       = 24,
    parameter int OUT_W     = 32,
    parameter int SHIFT     = 16,
    parameter int ROUND     = 1,
    parameter int SAT       = 1,
    parameter int NUM_STAGE = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_b_signed,
    input  logic [LANES*A_W-1:0]   in_a,
    input  logic [LANES*B_W-1:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat,
    output logic [LANES-1:0]       sat_sticky,
    input  logic                   clr_sticky
);

    logic                 adv;
    logic                 fire;
    logic [NUM_STAGE-1:0] vld;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[NUM_STAGE-1];
    assign fire      = out_valid && out_ready;

    // Bubbles travel with their own valid bit; nothing collapses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld <= '0;
        end else if (adv) begin
            vld[0] <= in_valid;
            for (int k = 1; k < NUM_STAGE; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

    // A set event in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sat_sticky <= '0;
        end else begin
            sat_sticky <= (clr_sticky ? '0 : sat_sticky)
                        | ({LANES{fire}} & out_sat);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        kernel_mhsa_mul_lane #(
            .A_W      (A_W),
            .B_W      (B_W),
            .OUT_W    (OUT_W),
            .SHIFT    (SHIFT),
            .ROUND    (ROUND),
            .SAT      (SAT),
            .NUM_STAGE(NUM_STAGE)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .adv     (adv),
            .b_signed(in_b_signed),
            .a       (in_a[lane_lo(i, A_W) +: A_W]),
            .b       (in_b[lane_lo(i, B_W) +: B_W]),
            .data    (out_data[lane_lo(i, OUT_W) +: OUT_W]),
            .sat     (out_sat[i])
        );
    end

endmodule

// File: tb/tb_kernel_mhsa_mul_pipe.sv
// Directed-vector bench for kernel_mhsa_mul_pipe: default build plus a
// NUM_STAGE=1 / SHIFT=0 / wrap build checked against a small model.
module tb_kernel_mhsa_mul_pipe;

    localparam int L = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic            iv0, ir0, ibs0, ov0, or0, clr0;
    logic [L*32-1:0] ia0, od0;
    logic [L*24-1:0] ib0;
    logic [L-1:0]    os0, st0;

    logic            iv1, ir1, ibs1, ov1, or1, clr1;
    logic [L*32-1:0] ia1, od1;
    logic [L*24-1:0] ib1;
    logic [L-1:0]    os1, st1;

    kernel_mhsa_mul_pipe u_dut0 (
        .clk(clk), .reset(rst),
        .in_valid(iv0), .in_ready(ir0), .in_b_signed(ibs0),
        .in_a(ia0), .in_b(ib0),
        .out_valid(ov0), .out_ready(or0),
        .out_data(od0), .out_sat(os0),
        .sat_sticky(st0), .clr_sticky(clr0)
    );

    kernel_mhsa_mul_pipe #(
        .NUM_STAGE(1), .SHIFT(0), .ROUND(1), .SAT(0)
    ) u_dut1 (
        .clk(clk), .reset(rst),
        .in_valid(iv1), .in_ready(ir1), .in_b_signed(ibs1),
        .in_a(ia1), .in_b(ib1),
        .out_valid(ov1), .out_ready(or1),
        .out_data(od1), .out_sat(os1),
        .sat_sticky(st1), .clr_sticky(clr1)
    );

    typedef struct {
        logic [31:0] a;
        logic [23:0] b;
        logic        bs;
        logic [31:0] exp;
        logic        sat;
    } vec_t;

    vec_t tv[10];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model1(input logic [31:0] a, input logic [23:0] b,
                                   input logic bs, output logic [31:0] d,
                                   output logic s);
        longint pa, pb, p;
        pa = longint'(signed'(a));
        pb = bs ? longint'(signed'(b)) : longint'({40'b0, b});
        p  = pa * pb;
        d  = p[31:0];
        s  = (p != longint'(signed'(p[31:0])));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [L-1:0]  stm;
        logic [31:0]   e, held, md;
        logic          ms, held_v;
        logic          pat [4];
        int            n, lane, sent, got, cyc, seen;

        tv[0] = '{32'hFFFFFFFD, 24'h010000, 1'b0, 32'hFFFFFFFD, 1'b0};
        tv[1] = '{32'h00000003, 24'h008000, 1'b0, 32'h00000002, 1'b0};
        tv[2] = '{32'hFFFFFFFD, 24'h008000, 1'b0, 32'hFFFFFFFF, 1'b0};
        tv[3] = '{32'h00000001, 24'h008000, 1'b0, 32'h00000001, 1'b0};
        tv[4] = '{32'h7FFFFFFF, 24'hFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1};
        tv[5] = '{32'h7FFFFFFF, 24'hFFFFFF, 1'b1, 32'hFFFF8000, 1'b0};
        tv[6] = '{32'h80000000, 24'hFFFFFF, 1'b0, 32'h80000000, 1'b1};
        tv[7] = '{32'hFFFFFFFF, 24'h008000, 1'b0, 32'h00000000, 1'b0};
        tv[8] = '{32'h00000064, 24'h800000, 1'b1, 32'hFFFFCE00, 1'b0};
        tv[9] = '{32'h12345678, 24'h000001, 1'b0, 32'h00001234, 1'b0};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b0;
        iv0 = 0; ibs0 = 0; or0 = 1; clr0 = 0; ia0 = '0; ib0 = '0;
        iv1 = 0; ibs1 = 0; or1 = 1; clr1 = 0; ia1 = '0; ib1 = '0;
        repeat (3) tick();
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_data", od0, 0);
        chk("rst_out_sat", os0, 0);
        chk("rst_sticky", st0, 0);
        chk("rst_out_valid1", ov1, 0);
        rst = 1'b1;
        tick();
        chk("in_ready_after_rst", ir0, 1);

        // Directed table, one beat at a time, one active lane per beat
        stm = '0;
        for (int v = 0; v < 10; v++) begin
            lane = v % L;
            ia0 = '0; ib0 = '0;
            ia0[lane*32 +: 32] = tv[v].a;
            ib0[lane*24 +: 24] = tv[v].b;
            ibs0 = tv[v].bs;
            iv0 = 1'b1;
            or0 = 1'b1;
            tick();
            iv0 = 1'b0;
            n = 1;
            while (!ov0 && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("vec%0d_latency", v), n, 3);
            for (int l = 0; l < L; l++) begin
                e = (l == lane) ? tv[v].exp : 32'h0;
                chk($sformatf("vec%0d_data_l%0d", v, l), od0[l*32 +: 32], e);
                chk($sformatf("vec%0d_sat_l%0d", v, l), os0[l],
                    (l == lane) ? tv[v].sat : 1'b0);
            end
            if (tv[v].sat) stm[lane] = 1'b1;
            tick();
            chk($sformatf("vec%0d_sticky", v), st0, stm);
            chk($sformatf("vec%0d_drain", v), ov0, 0);
        end

        // Backpressure stream with out_ready pattern 1,0,0,1
        sent = 0; got = 0; cyc = 0; held_v = 0; held = '0;
        ibs0 = 1'b0;
        while (got < 8 && cyc < 200) begin
            or0 = pat[cyc % 4];
            iv0 = (sent < 8);
            for (int l = 0; l < L; l++) begin
                ia0[l*32 +: 32] = 32'((sent + 1) * (l + 1));
                ib0[l*24 +: 24] = 24'h010000;
            end
            #1;
            if (held_v) begin
                chk("bp_stall_valid", ov0, 1);
                chk("bp_stall_hold", od0[31:0], held);
                held_v = 1'b0;
            end
            chk("bp_in_ready", ir0, !(ov0 && !or0));
            if (ov0 && or0) begin
                for (int l = 0; l < L; l++) begin
                    chk($sformatf("bp_beat%0d_l%0d", got, l),
                        od0[l*32 +: 32], 32'((got + 1) * (l + 1)));
                end
                got++;
            end else if (ov0) begin
                held = od0[31:0];
                held_v = 1'b1;
            end
            if (iv0 && ir0) sent++;
            tick();
            cyc++;
        end
        chk("bp_count", got, 8);
        iv0 = 1'b0;
        or0 = 1'b1;
        seen = 0;
        repeat (5) begin
            tick();
            if (ov0) seen++;
        end
        chk("bp_no_dup", seen, 0);

        // Reset mid-flight with three beats in the pipe
        or0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv0 = 1'b1;
            ia0 = {L{32'h00000777}};
            ib0 = {L{24'h010000}};
            tick();
        end
        iv0 = 1'b0;
        chk("mid_sticky_before", st0, stm);
        rst = 1'b0;
        tick();
        stm = '0;
        chk("mid_out_valid", ov0, 0);
        chk("mid_sticky", st0, 0);
        chk("mid_out_data", od0, 0);
        chk("mid_in_ready", ir0, 1);
        rst = 1'b1;
        or0 = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (ov0) seen++;
        end
        chk("mid_flushed", seen, 0);

        // Sticky clear racing a saturating handshake on lane 0
        ia0 = '0; ib0 = '0;
        ia0[31:0] = 32'h7FFFFFFF;
        ib0[23:0] = 24'hFFFFFF;
        ibs0 = 1'b0;
        iv0 = 1'b1;
        tick();
        iv0 = 1'b0;
        n = 1;
        while (!ov0 && n < 20) begin
            tick();
            n++;
        end
        chk("race_latency", n, 3);
        chk("race_sat", os0, 4'b0001);
        clr0 = 1'b1;
        tick();
        chk("race_set_wins", st0, 4'b0001);
        tick();
        chk("race_clear", st0, 0);
        clr0 = 1'b0;

        // NUM_STAGE=1, SHIFT=0, wrap build against the model
        for (int k = 0; k < 16; k++) begin
            for (int l = 0; l < L; l++) begin
                if (k == 0 && l == 0) begin
                    ia1[31:0] = 32'h7FFFFFFF;
                    ib1[23:0] = 24'hFFFFFF;
                end else if (k == 0 && l == 1) begin
                    ia1[63:32] = 32'd2;
                    ib1[47:24] = 24'd3;
                end else if (k % 2 == 1) begin
                    ia1[l*32 +: 32] = $urandom;
                    ib1[l*24 +: 24] = 24'($urandom);
                end else begin
                    ia1[l*32 +: 32] = 32'($urandom_range(0, 2000)) - 32'd1000;
                    ib1[l*24 +: 24] = 24'($urandom_range(0, 4000));
                end
            end
            ibs1 = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            iv1 = 1'b1;
            tick();
            iv1 = 1'b0;
            chk($sformatf("s1_beat%0d_latency", k), ov1, 1);
            for (int l = 0; l < L; l++) begin
                model1(ia1[l*32 +: 32], ib1[l*24 +: 24], ibs1, md, ms);
                chk($sformatf("s1_beat%0d_data_l%0d", k, l), od1[l*32 +: 32], md);
                chk($sformatf("s1_beat%0d_sat_l%0d", k, l), os1[l], ms);
            end
            if (k == 0) begin
                chk("s1_wrap_flag", os1[1:0], 2'b01);
                chk("s1_small_prod", od1[63:32], 32'd6);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_mhsa_mul_pipe.md
Name: kernel_mhsa_mul_pipe

Overview:
- Parametrised, multi-lane successor to the single-stage signed×unsigned multiplier cores used in the MHSA datapath.
- Each lane multiplies a signed activation by a fixed-point weight/scale. The weight is treated as unsigned or signed, selected per beat.
- Each lane then applies a configurable arithmetic right shift with optional round-half-up, and saturates or wraps to OUT_W.
- Uses a valid/ready handshake with backpressure and a programmable pipeline depth. Sits between the Q·K / softmax-scale stages and the accumulators.

Parameters:
- LANES, 4, number of parallel multiplier lanes sharing one handshake.
- A_W, 32, width of signed operand A per lane.
- B_W, 24, width of operand B per lane.
- OUT_W, 32, width of signed result per lane.
- SHIFT, 16, right-shift amount applied to the product; legal range 0..A_W+B_W-1.
- ROUND, 1, when 1 and SHIFT>0, add 2^(SHIFT-1) before the shift.
- SAT, 1, when 1 saturate to signed OUT_W range; when 0 keep the low OUT_W bits (wrap).
- NUM_STAGE, 3, total latency in accepted-advance cycles; minimum 1.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-low reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, block can accept a beat this cycle.
- in_b_signed, in, 1, 1 = treat B as signed, 0 = zero-extend B; carried with the beat.
- in_a, in, LANES*A_W, packed signed A operands; lane 0 in the LSBs.
- in_b, in, LANES*B_W, packed B operands.
- out_valid, out, 1, result beat valid.
- out_ready, in, 1, downstream accepts the beat.
- out_data, out, LANES*OUT_W, packed signed results.
- out_sat, out, LANES, per-lane flag: this beat was clipped (SAT=1) or overflowed/wrapped (SAT=0).
- sat_sticky, out, LANES, per-lane OR of out_sat over all handshaken beats since reset or clear.
- clr_sticky, in, 1, clear sat_sticky.

Behaviour:
- Reset (reset=0 at a clk edge):
  - All stage valid bits, out_valid and sat_sticky go to 0.
  - out_data and out_sat go to 0.
  - Internal data stage registers are not reset (DSP packing).
  - A reset mid-operation discards all in-flight beats; in_ready=1 on the cycle after release.
- Pipeline advance:
  - adv = !out_valid || out_ready. in_ready = adv (combinational, no input-to-output path other than this).
  - All stages shift only when adv=1. While adv=0 every stage holds, and in_valid is ignored.
  - A beat is accepted when in_valid && in_ready.
- Latency:
  - With continuous adv=1, a beat accepted at cycle t shows out_valid=1 at cycle t+NUM_STAGE.
  - Throughput is one beat per cycle. Bubbles are not collapsed; each stage carries its own valid bit.
- Arithmetic, per lane:
  - P = A × B' with P_W = A_W+B_W+1 bits signed.
  - B' = {B[B_W-1],B} when in_b_signed=1, otherwise {1'b0,B}.
  - R = (P + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (arithmetic shift, floor semantics, so ties round toward +inf).
  - Rounding add is done at P_W+1 bits, so it never overflows.
- Saturation, SAT=1:
  - If R > 2^(OUT_W-1)-1, output the max and set out_sat.
  - If R < -2^(OUT_W-1), output the min and set out_sat.
- Wrap, SAT=0:
  - Output R[OUT_W-1:0].
  - out_sat = 1 when the discarded bits are not a sign extension.
- Stage placement:
  - Stage 1 registers operands.
  - Multiply is split over the middle stages.
  - Round/shift/saturate sits in the last stage.
  - NUM_STAGE=1 collapses everything into one registered stage.
- Sticky flags:
  - sat_sticky[i] sets on out_valid && out_ready && out_sat[i].
  - When clr_sticky and a set event occur in the same cycle, the set wins (the flag reads 1).
- out_data and out_sat hold stable while out_valid && !out_ready.

Decomposition:
- Shared package kernel_mhsa_pkg:
  - P_W and rounding-constant functions.
  - Signed saturation-limit constants as functions of OUT_W.
  - A lane index slice helper.
- Natural sub-module: kernel_mhsa_mul_lane. It holds one lane's multiply, round, shift and saturate datapath and is driven by a shared adv enable; it is instantiated LANES times.
- Valid chain, handshake and sticky logic live in the top.

Test Plan:
1. Signed rounding, defaults, unsigned B: lane0 A=-3, B=0x010000 -> -3 (0xFFFFFFFD), out_sat=0; A=3, B=0x008000 -> 2; A=-3, B=0x008000 -> -1. Each output appears exactly 3 cycles after acceptance.
2. Saturation: A=0x7FFFFFFF, B=0xFFFFFF, in_b_signed=0 -> out_data 0x7FFFFFFF, out_sat=1, sat_sticky[0]=1. Same operands with in_b_signed=1 -> 0xFFFF8000, out_sat=0.
3. Backpressure: stream 8 beats with out_ready toggling 1,0,0,1,... -> all 8 results emerge in order with no loss or duplication. in_ready=0 exactly on the cycles where out_valid=1 and out_ready=0, and out_data stays stable during stalls.
4. Reset mid-flight: accept 3 beats, drive reset=0 for one cycle -> out_valid=0 and sat_sticky=0 the next cycle, and none of the 3 beats ever appears.
5. Sticky clear race: a saturating beat handshakes in the same cycle clr_sticky=1 -> sat_sticky stays 1; clr_sticky alone on the next cycle -> 0.
6. Parameter sweep: NUM_STAGE=1, SHIFT=0, ROUND=1, SAT=0, random operands vs. reference model -> exact match, latency 1, wrap flag correct.
